// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed data priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_read,
   input  logic [15:0] i_address,
   output logic [15:0] i_rdata,
   output logic        i_resp,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [15:0] d_address,
   input  logic [15:0] d_wdata,
   input  logic [1:0]  d_byte_enable,
   output logic [15:0] d_rdata,
   output logic        d_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   logic [1:0]  state;
   logic [15:0] lat_address;
   logic [15:0] lat_wdata;
   logic [1:0]  lat_be;
   logic        lat_write;
   logic        d_req;
   logic        grant_d;
   logic        grant_i;
   logic        serving;
   assign d_req = d_read | d_write;
`ifdef MEM_ARB_RR_EN
   logic last_grant;
   // last_grant: 1 = data port won the previous grant
   assign grant_d = d_req && !(i_read && last_grant);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_grant <= 1'b0;
      else if (state == IDLE && (d_req || i_read)) last_grant <= grant_d;
`else
   assign grant_d = d_req;
`endif
   assign grant_i = i_read && !grant_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         lat_address <= '0;
         lat_wdata   <= '0;
         lat_be      <= '0;
         lat_write   <= 1'b0;
      end else if (state == IDLE) begin
         if (grant_d) begin
            state       <= SERVE_D;
            lat_address <= d_address;
            lat_wdata   <= d_wdata;
            lat_be      <= d_write ? d_byte_enable : 2'b11;
            lat_write   <= d_write;
         end else if (grant_i) begin
            state       <= SERVE_I;
            lat_address <= i_address;
            lat_wdata   <= '0;
            lat_be      <= 2'b11;
            lat_write   <= 1'b0;
         end
      end else if (mem_resp || state == 2'd3) begin
         state <= IDLE;
      end
   assign serving         = state == SERVE_I || state == SERVE_D;
   assign mem_read        = serving && !lat_write;
   assign mem_write       = serving && lat_write;
   assign mem_byte_enable = serving ? lat_be : 2'b00;
   assign mem_address     = serving ? lat_address : 16'h0;
   assign mem_wdata       = serving ? lat_wdata : 16'h0;
   assign i_resp          = state == SERVE_I && mem_resp;
   assign d_resp          = state == SERVE_D && mem_resp;
   assign i_rdata         = i_resp ? mem_rdata : 16'h0;
   assign d_rdata         = d_resp ? mem_rdata : 16'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_read = 1'b0;
   logic [15:0] i_address = '0;
   logic [15:0] i_rdata;
   logic        i_resp;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [15:0] d_address = '0;
   logic [15:0] d_wdata = '0;
   logic [1:0]  d_byte_enable = '0;
   logic [15:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );
   task automatic test_reset;
      rst_n = 1'b0;
      mem_resp = 1'b1;
      mem_rdata = 16'h5A5A;
      @(negedge clk);
      tests++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== 36'h0) begin
         fails++;
         $display("FAIL reset_mem: got rd=%b wr=%b be=%b a=%h wd=%h, expected all 0", mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata);
      end
      tests++;
      if ({i_resp, d_resp, i_rdata, d_rdata} !== 34'h0) begin
         fails++;
         $display("FAIL reset_resp: got i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, expected 0", i_resp, d_resp, i_rdata, d_rdata);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = '0;
      rst_n = 1'b1;
   endtask
   task automatic test_fetch;
      i_read = 1'b1;
      i_address = 16'h1000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h1000 || mem_byte_enable !== 2'b11) begin
            fails++;
            $display("FAIL fetch_req%0d: got rd=%b wr=%b a=%h be=%b, expected 1 0 1000 11", c, mem_read, mem_write, mem_address, mem_byte_enable);
         end
         if (c < 2) begin
            tests++;
            if (i_resp !== 1'b0) begin
               fails++;
               $display("FAIL fetch_early_resp%0d: got %b expected 0", c, i_resp);
            end
         end
      end
      mem_resp = 1'b1;
      mem_rdata = 16'hABCD;
      #1;
      tests++;
      if (i_resp !== 1'b1 || i_rdata !== 16'hABCD || d_resp !== 1'b0 || d_rdata !== 16'h0) begin
         fails++;
         $display("FAIL fetch_resp: got i_resp=%b i_rdata=%h d_resp=%b d_rdata=%h, expected 1 abcd 0 0000", i_resp, i_rdata, d_resp, d_rdata);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = '0;
      i_read = 1'b0;
      #1;
      tests++;
      if (mem_read !== 1'b0 || i_resp !== 1'b0 || mem_address !== 16'h0) begin
         fails++;
         $display("FAIL fetch_idle: got rd=%b i_resp=%b a=%h, expected 0 0 0000", mem_read, i_resp, mem_address);
      end
   endtask
   task automatic test_write;
      @(negedge clk);
      d_write = 1'b1;
      d_address = 16'h2002;
      d_wdata = 16'h00FF;
      d_byte_enable = 2'b01;
      @(negedge clk);
      tests++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h2002 || mem_wdata !== 16'h00FF || mem_byte_enable !== 2'b01) begin
         fails++;
         $display("FAIL write_req: got wr=%b rd=%b a=%h wd=%h be=%b, expected 1 0 2002 00ff 01", mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable);
      end
      @(negedge clk);
      mem_resp = 1'b1;
      #1;
      tests++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0 || mem_read !== 1'b0) begin
         fails++;
         $display("FAIL write_resp: got d_resp=%b i_resp=%b rd=%b, expected 1 0 0", d_resp, i_resp, mem_read);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      d_write = 1'b0;
      #1;
      tests++;
      if (mem_write !== 1'b0 || d_resp !== 1'b0 || mem_byte_enable !== 2'b00 || mem_wdata !== 16'h0) begin
         fails++;
         $display("FAIL write_idle: got wr=%b d_resp=%b be=%b wd=%h, expected 0 0 00 0000", mem_write, d_resp, mem_byte_enable, mem_wdata);
      end
   endtask
   task automatic test_write_wins;
      @(negedge clk);
      d_read = 1'b1;
      d_write = 1'b1;
      d_address = 16'h2100;
      d_wdata = 16'h1234;
      d_byte_enable = 2'b10;
      @(negedge clk);
      tests++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_byte_enable !== 2'b10) begin
         fails++;
         $display("FAIL write_wins: got wr=%b rd=%b be=%b, expected 1 0 10", mem_write, mem_read, mem_byte_enable);
      end
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      d_read = 1'b0;
      d_write = 1'b0;
   endtask
   task automatic test_contention;
      logic exp_d;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      i_read = 1'b1;
      d_read = 1'b1;
      i_address = 16'h6000;
      d_address = 16'h5000;
      for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
         exp_d = (t % 2) == 0;
`else
         exp_d = t == 0;
`endif
         @(negedge clk);
         tests++;
         if (mem_read !== 1'b1 || mem_address !== (exp_d ? 16'h5000 : 16'h6000)) begin
            fails++;
            $display("FAIL grant%0d: got rd=%b a=%h, expected 1 %h", t, mem_read, mem_address, exp_d ? 16'h5000 : 16'h6000);
         end
         @(negedge clk);
         mem_resp = 1'b1;
         mem_rdata = 16'h1100 + 16'(t);
         #1;
         tests++;
         if (d_resp !== exp_d || i_resp !== !exp_d || (exp_d ? d_rdata : i_rdata) !== 16'h1100 + 16'(t)) begin
            fails++;
            $display("FAIL grant_resp%0d: got d_resp=%b i_resp=%b d_rdata=%h i_rdata=%h, expected d_resp=%b", t, d_resp, i_resp, d_rdata, i_rdata, exp_d);
         end
         @(negedge clk);
         mem_resp = 1'b0;
         mem_rdata = '0;
`ifndef MEM_ARB_RR_EN
         d_read = 1'b0;
`endif
         if (t == 3) begin
            i_read = 1'b0;
            d_read = 1'b0;
         end
         #1;
         tests++;
         if (mem_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            fails++;
            $display("FAIL bubble%0d: got rd=%b i_resp=%b d_resp=%b, expected 0 0 0", t, mem_read, i_resp, d_resp);
         end
      end
   endtask
   task automatic test_addr_change;
      @(negedge clk);
      d_read = 1'b1;
      d_address = 16'h3000;
      @(negedge clk);
      d_address = 16'h4000;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            mem_resp = 1'b1;
            #1;
         end
         tests++;
         if (mem_address !== 16'h3000 || mem_read !== 1'b1) begin
            fails++;
            $display("FAIL addr_hold%0d: got a=%h rd=%b, expected 3000 1", c, mem_address, mem_read);
         end
      end
      tests++;
      if (d_resp !== 1'b1) begin
         fails++;
         $display("FAIL addr_resp: got d_resp=%b expected 1", d_resp);
      end
      @(negedge clk);
      mem_resp = 1'b0;
      d_read = 1'b0;
      d_address = '0;
   endtask
   task automatic test_idle_resp;
      @(negedge clk);
      mem_resp = 1'b1;
      mem_rdata = 16'hFFFF;
      #1;
      tests++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
         fails++;
         $display("FAIL idle_resp: got i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, expected 0", i_resp, d_resp, i_rdata, d_rdata);
      end
      @(negedge clk);
      tests++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
         fails++;
         $display("FAIL idle_stay: got rd=%b wr=%b i_resp=%b d_resp=%b, expected 0", mem_read, mem_write, i_resp, d_resp);
      end
      mem_resp = 1'b0;
      mem_rdata = '0;
   endtask
   task automatic test_reset_mid;
      @(negedge clk);
      i_read = 1'b1;
      i_address = 16'h7000;
      @(negedge clk);
      tests++;
      if (mem_read !== 1'b1 || mem_address !== 16'h7000) begin
         fails++;
         $display("FAIL mid_serve: got rd=%b a=%h, expected 1 7000", mem_read, mem_address);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_resp} !== 37'h0) begin
         fails++;
         $display("FAIL mid_reset: got rd=%b a=%h be=%b i_resp=%b, expected all 0", mem_read, mem_address, mem_byte_enable, i_resp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      i_read = 1'b0;
      mem_resp = 1'b1;
      mem_rdata = 16'hBEEF;
      #1;
      tests++;
      if (i_resp !== 1'b0 || i_rdata !== 16'h0) begin
         fails++;
         $display("FAIL mid_late_resp: got i_resp=%b i_rdata=%h, expected 0 0000", i_resp, i_rdata);
      end
      @(negedge clk);
      tests++;
      if (mem_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
         fails++;
         $display("FAIL mid_idle: got rd=%b i_resp=%b d_resp=%b, expected 0 0 0", mem_read, i_resp, d_resp);
      end
      mem_resp = 1'b0;
      mem_rdata = '0;
   endtask
   initial begin
      test_reset;
      test_fetch;
      test_write;
      test_write_wins;
      test_contention;
      test_addr_change;
      test_idle_resp;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
